// File: rtl/matmul_engine.sv
// matmul_engine: output-stationary systolic matrix multiplier.
// Computes C = A x B for signed operands. The accumulators wrap and set a
// sticky overflow flag per result element. Operands and dimension codes are
// captured once per operation, so the operand store may change them after
// LOAD. done_o is a one-cycle write strobe, and start_i must fall before
// another operation can begin.
module matmul_engine #(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUS_WIDTH  = 32,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [MAX_DIM*BUS_WIDTH-1:0]        a_i,
    input  logic [MAX_DIM*BUS_WIDTH-1:0]        b_i,
    input  logic [1:0]                          dim_n_i,
    input  logic [1:0]                          dim_k_i,
    input  logic [1:0]                          dim_m_i,
    output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] c_o,
    output logic [MAX_DIM*MAX_DIM-1:0]          flags_o,
    output logic                                done_o,
    output logic                                busy_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_COMPUTE  = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_WAIT_LOW = 3'd4;

    localparam int CNT_W  = 8;
    localparam int DIM_W  = 4;
    localparam int PROD_W = 2 * DATA_WIDTH;

    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] compute_len;
    logic [DIM_W-1:0] dim_n;
    logic [DIM_W-1:0] dim_k;
    logic [DIM_W-1:0] dim_m;
    logic             load_now;
    logic             compute_now;

    logic signed [DATA_WIDTH-1:0] a_mat  [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0] b_mat  [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0] a_edge [MAX_DIM];
    logic signed [DATA_WIDTH-1:0] b_edge [MAX_DIM];
    logic signed [DATA_WIDTH-1:0] a_fwd  [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0] b_fwd  [MAX_DIM][MAX_DIM];

    // Size is code+1, limited to the physical array size.
    function automatic logic [DIM_W-1:0] clamp_dim(input logic [1:0] code);
        logic [DIM_W-1:0] size;
        size = DIM_W'(code) + DIM_W'(1);
        if (size > DIM_W'(MAX_DIM)) begin
            size = DIM_W'(MAX_DIM);
        end
        return size;
    endfunction

    assign load_now    = (state == ST_LOAD);
    assign compute_now = (state == ST_COMPUTE);
    assign done_o      = (state == ST_DONE);
    assign busy_o      = (state == ST_LOAD) || (state == ST_COMPUTE) || (state == ST_DONE);

    // Sequencer: the wavefront needs K+N+M-2 cycles to reach the far corner PE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            cycle_cnt   <= '0;
            compute_len <= '0;
            dim_n       <= '0;
            dim_k       <= '0;
            dim_m       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dim_n       <= clamp_dim(dim_n_i);
                    dim_k       <= clamp_dim(dim_k_i);
                    dim_m       <= clamp_dim(dim_m_i);
                    compute_len <= CNT_W'(clamp_dim(dim_n_i)) + CNT_W'(clamp_dim(dim_k_i))
                                 + CNT_W'(clamp_dim(dim_m_i)) - CNT_W'(2);
                    cycle_cnt   <= '0;
                    state       <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (cycle_cnt == compute_len - CNT_W'(1)) begin
                        state <= ST_DONE;
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!start_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand snapshot; b_mat is stored as [k][j] to match the B(k,j) layout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int k = 0; k < MAX_DIM; k++) begin
                    a_mat[i][k] <= '0;
                    b_mat[i][k] <= '0;
                end
            end
        end else if (load_now) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int k = 0; k < MAX_DIM; k++) begin
                    a_mat[i][k] <= a_i[i*BUS_WIDTH + k*DATA_WIDTH +: DATA_WIDTH];
                    b_mat[k][i] <= b_i[i*BUS_WIDTH + k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Skewed edge feed: row i / column i sees element k at cycle i+k, zero elsewhere.
    always_comb begin
        for (int i = 0; i < MAX_DIM; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
            for (int k = 0; k < MAX_DIM; k++) begin
                if ((int'(cycle_cnt) == i + k) && (k < int'(dim_k))) begin
                    if (i < int'(dim_n)) begin
                        a_edge[i] = a_mat[i][k];
                    end
                    if (i < int'(dim_m)) begin
                        b_edge[i] = b_mat[k][i];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
            logic signed [DATA_WIDTH-1:0] a_in;
            logic signed [DATA_WIDTH-1:0] b_in;
            logic signed [DATA_WIDTH-1:0] a_reg;
            logic signed [DATA_WIDTH-1:0] b_reg;
            logic signed [PROD_W-1:0]     prod;
            logic signed [BUS_WIDTH-1:0]  prod_ext;
            logic signed [BUS_WIDTH-1:0]  acc;
            logic signed [BUS_WIDTH-1:0]  sum;
            logic                         ovf_now;
            logic                         flag;
            logic                         active;

            if (gj == 0) begin : g_a_edge
                assign a_in = a_edge[gi];
            end else begin : g_a_fwd
                assign a_in = a_fwd[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_in = b_edge[gj];
            end else begin : g_b_fwd
                assign b_in = b_fwd[gi-1][gj];
            end

            assign a_fwd[gi][gj] = a_reg;
            assign b_fwd[gi][gj] = b_reg;
            assign prod     = PROD_W'(a_in) * PROD_W'(b_in);
            assign prod_ext = BUS_WIDTH'(prod);
            assign sum      = acc + prod_ext;
            assign ovf_now  = (acc[BUS_WIDTH-1] == prod_ext[BUS_WIDTH-1])
                           && (sum[BUS_WIDTH-1] != acc[BUS_WIDTH-1]);
            assign active   = (gi < int'(dim_n)) && (gj < int'(dim_m));

            // Processing element: forward operands, accumulate only inside the live N x M window.
            always_ff @(posedge clk_i) begin
                if (rst_i || load_now) begin
                    a_reg <= '0;
                    b_reg <= '0;
                    acc   <= '0;
                    flag  <= 1'b0;
                end else if (compute_now) begin
                    a_reg <= a_in;
                    b_reg <= b_in;
                    if (active) begin
                        acc <= sum;
                        if (ovf_now) begin
                            flag <= 1'b1;
                        end
                    end
                end
            end

            assign c_o[(gi*MAX_DIM+gj)*BUS_WIDTH +: BUS_WIDTH] = acc;
            assign flags_o[gi*MAX_DIM+gj]                      = flag;
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: randomized and directed runs of matmul_engine against a
// plain-arithmetic matrix product model. Two instances are used: 8/32
// (4x4 array) and 8/16 (2x2 array, overflow and clamping cases).
module tb_matmul_engine;

    localparam int DW   = 8;
    localparam int BW   = 32;
    localparam int MD   = BW / DW;
    localparam int BWS  = 16;
    localparam int MDS  = BWS / DW;

    logic                  clk_i = 1'b0;
    logic                  rst_i;

    logic                  start_i;
    logic [MD*BW-1:0]      a_i, b_i;
    logic [1:0]            dim_n_i, dim_k_i, dim_m_i;
    logic [MD*MD*BW-1:0]   c_o;
    logic [MD*MD-1:0]      flags_o;
    logic                  done_o, busy_o;

    logic                  start_s;
    logic [MDS*BWS-1:0]    a_s, b_s;
    logic [1:0]            dn_s, dk_s, dm_s;
    logic [MDS*MDS*BWS-1:0] c_s;
    logic [MDS*MDS-1:0]    flags_s;
    logic                  done_s, busy_s;

    int     errors = 0;
    int     checks = 0;
    int     a_m [4][4];
    int     b_m [4][4];
    longint exp_c [4][4];
    bit     exp_f [4][4];

    always #5 clk_i = ~clk_i;

    matmul_engine #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
        .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i),
        .c_o(c_o), .flags_o(flags_o), .done_o(done_o), .busy_o(busy_o)
    );

    matmul_engine #(.DATA_WIDTH(DW), .BUS_WIDTH(BWS)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_s), .a_i(a_s), .b_i(b_s),
        .dim_n_i(dn_s), .dim_k_i(dk_s), .dim_m_i(dm_s),
        .c_o(c_s), .flags_o(flags_s), .done_o(done_s), .busy_o(busy_s)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: C = A x B over the live sizes, wrapping signed accumulation with sticky overflow.
    function automatic void computeExpected(input int n, input int k, input int m, input int bus);
        longint lim;
        longint acc;
        longint s;
        lim = longint'(1) << (bus - 1);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_c[i][j] = 0;
                exp_f[i][j] = 1'b0;
                if (i < n && j < m) begin
                    acc = 0;
                    for (int kk = 0; kk < k; kk++) begin
                        s = acc + longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
                        if (s >= lim || s < -lim) begin
                            exp_f[i][j] = 1'b1;
                        end
                        s = s & ((lim << 1) - 1);
                        if (s >= lim) begin
                            s = s - (lim << 1);
                        end
                        acc = s;
                    end
                    exp_c[i][j] = acc;
                end
            end
        end
    endfunction

    function automatic int clampSize(input int code, input int maxd);
        return (code + 1 > maxd) ? maxd : code + 1;
    endfunction

    task automatic randomOperands();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = int'($urandom_range(255, 0)) - 128;
                b_m[i][k] = int'($urandom_range(255, 0)) - 128;
            end
        end
    endtask

    task automatic packMain();
        for (int i = 0; i < MD; i++) begin
            for (int k = 0; k < MD; k++) begin
                a_i[i*BW + k*DW +: DW] = 8'(a_m[i][k]);
                b_i[i*BW + k*DW +: DW] = 8'(b_m[k][i]);
            end
        end
    endtask

    task automatic checkMainResult(input string tag);
        logic [15:0] ef;
        logic [63:0] mask;
        mask = 64'hFFFF_FFFF;
        ef   = '0;
        for (int i = 0; i < MD; i++) begin
            for (int j = 0; j < MD; j++) begin
                checkOutput($sformatf("%s_c%0d%0d", tag, i, j), 64'(c_o[(i*MD+j)*BW +: BW]),
                            64'(exp_c[i][j]) & mask);
                ef[i*MD+j] = exp_f[i][j];
            end
        end
        checkOutput({tag, "_flags"}, 64'(flags_o), 64'(ef));
    endtask

    // One operation on the 4x4 instance; optionally disturb inputs after capture and hold start.
    task automatic applyStimulus(input string tag, input int nc, input int kc, input int mc,
                                 input bit scramble, input bit drop_start, input bit hold_high);
        int n, k, m, edges, extra;
        bit seen;
        n = clampSize(nc, MD);
        k = clampSize(kc, MD);
        m = clampSize(mc, MD);
        computeExpected(n, k, m, BW);
        @(negedge clk_i);
        packMain();
        dim_n_i = 2'(nc);
        dim_k_i = 2'(kc);
        dim_m_i = 2'(mc);
        start_i = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 64) begin
            @(posedge clk_i);
            #1;
            edges++;
            if (edges == 1) begin
                checkOutput({tag, "_busy_load"}, 64'(busy_o), 64'd1);
            end
            if (done_o) begin
                seen = 1'b1;
            end else if (edges >= 2) begin
                if (scramble) begin
                    a_i = {$urandom(), $urandom(), $urandom(), $urandom()};
                    b_i = {$urandom(), $urandom(), $urandom(), $urandom()};
                    dim_n_i = 2'($urandom());
                    dim_k_i = 2'($urandom());
                    dim_m_i = 2'($urandom());
                end
                if (drop_start) begin
                    start_i = 1'b0;
                end
            end
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_latency"}, 64'(edges), 64'(n + k + m));
        checkMainResult(tag);
        @(posedge clk_i);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(done_o), 64'd0);
        checkOutput({tag, "_busy_after"}, 64'(busy_o), 64'd0);
        if (hold_high) begin
            extra = 0;
            repeat (5) begin
                @(posedge clk_i);
                #1;
                if (done_o || busy_o) extra++;
            end
            checkOutput({tag, "_no_restart"}, 64'(extra), 64'd0);
        end
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput({tag, "_c_held"}, 64'(c_o[0 +: BW]), 64'(exp_c[0][0]) & 64'hFFFF_FFFF);
    endtask

    // Reset lands in COMPUTE cycle 3 while start stays high; a fresh run must follow.
    task automatic resetMidCompute();
        int edges;
        bit seen;
        randomOperands();
        computeExpected(4, 4, 4, BW);
        @(negedge clk_i);
        packMain();
        dim_n_i = 2'd3;
        dim_k_i = 2'd3;
        dim_m_i = 2'd3;
        start_i = 1'b1;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("rst_c_zero", 64'(|c_o), 64'd0);
        checkOutput("rst_flags_zero", 64'(flags_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 64) begin
            @(posedge clk_i);
            #1;
            edges++;
            if (done_o) seen = 1'b1;
        end
        checkOutput("rst_done_seen", 64'(seen), 64'd1);
        checkOutput("rst_latency", 64'(edges), 64'd12);
        checkMainResult("rst");
        start_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    // One operation on the 2x2 / 16-bit instance.
    task automatic runSmall(input string tag, input int nc, input int kc, input int mc);
        int n, k, m, edges;
        bit seen;
        logic [3:0] ef;
        n = clampSize(nc, MDS);
        k = clampSize(kc, MDS);
        m = clampSize(mc, MDS);
        computeExpected(n, k, m, BWS);
        @(negedge clk_i);
        for (int i = 0; i < MDS; i++) begin
            for (int kk = 0; kk < MDS; kk++) begin
                a_s[i*BWS + kk*DW +: DW] = 8'(a_m[i][kk]);
                b_s[i*BWS + kk*DW +: DW] = 8'(b_m[kk][i]);
            end
        end
        dn_s = 2'(nc);
        dk_s = 2'(kc);
        dm_s = 2'(mc);
        start_s = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 64) begin
            @(posedge clk_i);
            #1;
            edges++;
            if (done_s) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_latency"}, 64'(edges), 64'(n + k + m));
        ef = '0;
        for (int i = 0; i < MDS; i++) begin
            for (int j = 0; j < MDS; j++) begin
                checkOutput($sformatf("%s_c%0d%0d", tag, i, j), 64'(c_s[(i*MDS+j)*BWS +: BWS]),
                            64'(exp_c[i][j]) & 64'hFFFF);
                ef[i*MDS+j] = exp_f[i][j];
            end
        end
        checkOutput({tag, "_flags"}, 64'(flags_s), 64'(ef));
        start_s = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        a_i = '0; b_i = '0; dim_n_i = '0; dim_k_i = '0; dim_m_i = '0;
        start_s = 1'b0;
        a_s = '0; b_s = '0; dn_s = '0; dk_s = '0; dm_s = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_c", 64'(|c_o), 64'd0);
        checkOutput("reset_flags", 64'(flags_o), 64'd0);
        checkOutput("reset_done", 64'(done_o), 64'd0);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;

        $display("[TB] 2x2x2 directed product");
        randomOperands();
        a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
        b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
        applyStimulus("d222", 1, 1, 1, 1'b0, 1'b0, 1'b1);
        checkOutput("d222_c11_const", 64'(c_o[5*BW +: BW]), 64'd50);

        $display("[TB] 4x4x4 identity times ramp");
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = (i == k) ? 1 : 0;
                b_m[i][k] = 4 * i + k;
            end
        end
        applyStimulus("ident", 3, 3, 3, 1'b1, 1'b0, 1'b0);

        $display("[TB] 3x2x4 signed with zero column");
        randomOperands();
        a_m[0][0] = -1; a_m[0][1] = -2;
        b_m[0][0] = 3;  b_m[1][0] = 4;
        for (int k = 0; k < 4; k++) b_m[k][3] = 0;
        applyStimulus("signed", 2, 1, 3, 1'b1, 1'b1, 1'b0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            randomOperands();
            applyStimulus($sformatf("rnd%0d", r), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                          int'($urandom_range(3, 0)), 1'b1, bit'($urandom_range(1, 0)),
                          bit'($urandom_range(1, 0)));
        end

        $display("[TB] reset during compute");
        resetMidCompute();

        $display("[TB] 16-bit accumulator overflow");
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = -128;
                b_m[i][k] = -128;
            end
        end
        runSmall("ovf", 1, 1, 1);

        $display("[TB] 16-bit randomized and clamped runs");
        for (int r = 0; r < 4; r++) begin
            randomOperands();
            runSmall($sformatf("small%0d", r), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
